// File: rtl/safe_mult_pipe.sv
// -----------------------------------------------------------------------------
// safe_mult_pipe
//   Pipelined fixed-point signed multiplier, Q = A * B.
//   Register 1 holds the full-precision product. Any further registers are plain
//   delay stages. Rounding, range check and saturate/wrap happen in front of the
//   output register. With PIPE_STAGES = 1, all of this is done in one stage.
//   The pipeline uses one global stall signal: every stage advances only when the
//   output is empty or is being taken downstream.
//
// Ports
//   clk        : clock
//   rst        : synchronous reset, active-high
//   s_valid    : operand pair valid
//   s_ready    : block accepts an operand pair this cycle
//   A, B       : signed operands (A_FRAC / B_FRAC fractional bits)
//   m_valid    : Q / overflow valid
//   m_ready    : downstream accepts the result
//   Q          : signed result (Q_FRAC fractional bits)
//   overflow   : this result was outside the Q range
//   ovf_sticky : latched OR of overflow over results taken downstream
//   ovf_clear  : clears ovf_sticky (a same-cycle set wins)
// -----------------------------------------------------------------------------
module safe_mult_pipe #(
    parameter int A_WIDTH     = 16,
    parameter int A_FRAC      = 14,
    parameter int B_WIDTH     = 16,
    parameter int B_FRAC      = 14,
    parameter int Q_WIDTH     = 16,
    parameter int Q_FRAC      = 14,
    parameter int PIPE_STAGES = 2,
    parameter int ROUND_MODE  = 0,
    parameter int SATURATE    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [Q_WIDTH-1:0] Q,
    output logic               overflow,
    output logic               ovf_sticky,
    input  logic               ovf_clear
);

    localparam int PW  = A_WIDTH + B_WIDTH;           // full product width
    localparam int D   = A_FRAC + B_FRAC - Q_FRAC;    // bits to drop (<0: bits to add)
    localparam int RSH = (D > 0) ? D : 0;
    localparam int LSH = (D < 0) ? -D : 0;
    localparam int RS1 = (RSH > 0) ? RSH - 1 : 0;
    // Working width: product + 1 guard bit for the rounding carry + any left shift.
    // It is also at least one bit wider than Q, so the range compare is exact.
    localparam int RW  = PW + 1 + LSH;
    localparam int CW  = ((RW > Q_WIDTH) ? RW : Q_WIDTH) + 1;

    localparam logic signed [CW-1:0] RND   = CW'(ROUND_MODE != 0 && RSH > 0) << RS1;
    localparam logic signed [CW-1:0] Q_MAX = {{(CW-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] Q_MIN = {{(CW-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};

    // Rescale a product to Q LSBs. Returns {overflow, q}.
    function automatic logic [Q_WIDTH:0] scale_q(input logic [PW-1:0] p);
        logic signed [CW-1:0] x;
        logic                 ovf;
        logic [Q_WIDTH-1:0]   q;
        // NOTE: blocking assignments are correct here. This is a pure combinational
        // chain of steps. Only clocked state below uses non-blocking assignments.
        x   = CW'(signed'(p));
        x   = x + RND;
        x   = x >>> RSH;
        x   = x <<< LSH;
        ovf = (x > Q_MAX) || (x < Q_MIN);
        if (SATURATE != 0 && ovf)
            q = x[CW-1] ? Q_MIN[Q_WIDTH-1:0] : Q_MAX[Q_WIDTH-1:0];
        else
            q = x[Q_WIDTH-1:0];
        return {ovf, q};
    endfunction

    logic                        en;
    logic signed [A_WIDTH-1:0]   a_s;
    logic signed [B_WIDTH-1:0]   b_s;
    logic [PW-1:0]               prod_now;
    logic [PW-1:0]               last_prod;
    logic                        last_vld;
    logic [Q_WIDTH:0]            scaled;

    assign en       = !m_valid || m_ready;
    assign s_ready  = en;
    assign a_s      = signed'(A);
    assign b_s      = signed'(B);
    assign prod_now = PW'(a_s) * PW'(b_s);

    generate
        if (PIPE_STAGES == 1) begin : g_single
            assign last_prod = prod_now;
            assign last_vld  = s_valid;
        end else begin : g_multi
            logic [PW-1:0] prod_q [PIPE_STAGES-1];
            logic          vld_q  [PIPE_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < PIPE_STAGES - 1; k++)
                        vld_q[k] <= 1'b0;
                end else if (en) begin
                    vld_q[0] <= s_valid;
                    for (int k = 1; k < PIPE_STAGES - 1; k++)
                        vld_q[k] <= vld_q[k-1];
                end
            end

            // NOTE: the product registers are not reset. Their contents matter only
            // when the valid bit that travels with them is set, and those valid bits
            // are reset.
            always_ff @(posedge clk) begin
                if (en) begin
                    prod_q[0] <= prod_now;
                    for (int k = 1; k < PIPE_STAGES - 1; k++)
                        prod_q[k] <= prod_q[k-1];
                end
            end

            assign last_prod = prod_q[PIPE_STAGES-2];
            assign last_vld  = vld_q[PIPE_STAGES-2];
        end
    endgenerate

    assign scaled = scale_q(last_prod);

    // Output register. It is loaded only with real results, so a bubble leaves the
    // last Q visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            Q        <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            m_valid <= last_vld;
            if (last_vld) begin
                Q        <= scaled[Q_WIDTH-1:0];
                overflow <= scaled[Q_WIDTH];
            end
        end
    end

    // A set from a completed overflow handshake has priority over ovf_clear.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (m_valid && m_ready && overflow)
            ovf_sticky <= 1'b1;
        else if (ovf_clear)
            ovf_sticky <= 1'b0;
    end

endmodule
